// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NREQ requesters.
// Each grant becomes a header/payload/checksum frame, paced on tx_done_tick.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 40000,
    parameter int TO_W    = 16,
    parameter int GAP_CYC = 16,
    parameter int GAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_din,
    input  logic              tx_done_tick,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        GAP
    } state_t;

    state_t            state_q;
    logic [2:0]        ptr_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        pay_q;
    logic [7:0]        chk_q;
    logic [7:0]        din_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              start_q;
    logic              busy_q;

    logic [NREQ-1:0]   req_rot;
    logic              found;
    int                gi;
    int                pn;
    logic [2:0]        g;
    logic [2:0]        ptr_d;
    logic [7:0]        pay_d;
    logic [7:0]        hdr_d;
    logic              last_byte;
    logic              timed_out;

    // Rotate req so bit 0 is the requester at ptr, then take the first set bit.
    always_comb begin
        req_rot = (req >> ptr_q) | (req << (NREQ - int'(ptr_q)));
        found   = 1'b0;
        gi      = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                gi    = int'(ptr_q) + j;
                if (gi >= NREQ) begin
                    gi = gi - NREQ;
                end
            end
        end
        pn = gi + 1;
        if (pn >= NREQ) begin
            pn = 0;
        end
        g     = 3'(gi);
        ptr_d = 3'(pn);
        pay_d = 8'(req_data >> {g, 3'b000});
        hdr_d = 8'hA0 | {5'b00000, g};
    end

    assign last_byte = (byte_idx_q == 2'd2);
    assign timed_out = (int'(to_cnt_q) >= TIMEOUT - 1);

    // A done tick on the timeout cycle wins, so the error needs the tick absent.
    assign grant       = (!reset && state_q == IDLE && found)
                         ? ({{(NREQ-1){1'b0}}, 1'b1} << g) : '0;
    assign frame_done  = !reset && state_q == WAIT && tx_done_tick && last_byte;
    assign err_timeout = !reset && state_q == WAIT && !tx_done_tick && timed_out;

    assign tx_start = start_q;
    assign tx_din   = din_q;
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            byte_idx_q <= '0;
            pay_q      <= '0;
            chk_q      <= '0;
            din_q      <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        pay_q      <= pay_d;
                        chk_q      <= hdr_d ^ pay_d;
                        din_q      <= hdr_d;
                        ptr_q      <= ptr_d;
                        byte_idx_q <= '0;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    to_cnt_q <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (to_cnt_q != '1) begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                    if (tx_done_tick && !last_byte) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        din_q      <= (byte_idx_q == 2'd0) ? pay_q : chk_q;
                        start_q    <= 1'b1;
                        state_q    <= LOAD;
                    end else if (tx_done_tick || timed_out) begin
                        gap_cnt_q <= '0;
                        if (GAP_CYC == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (int'(gap_cnt_q) >= GAP_CYC - 1) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (gap_cnt_q != '1) begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: timestamp-based frame model checked every cycle,
// a uart_tx stand-in answering each tx_start after 10 cycles, and literal pins.
module tb_uart_tx_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 50;
    localparam int GAP_CYC = 3;
    localparam int UART_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  grant;
    logic        txStart;
    logic [7:0]  txDin;
    logic        txDone;
    logic        busy;
    logic        frameDone;
    logic        errTimeout;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    int startNo = 0;
    int doneAt = -1;
    int skipIdx = -1;
    int longIdx = -1;
    int injectAt = -1;

    bit         mInFrame = 1'b0;
    int         mIdleFrom = 0;
    int         mLoadAt = 0;
    int         mGrantCyc = 0;
    int         mByteNo = 0;
    int         mPtr = 0;
    logic [7:0] mFrame[3];
    logic [7:0] mDin = 8'h00;

    logic [7:0] startBytes[$];
    int         startCycles[$];
    int         grantIdx[$];
    int         grantCycles[$];
    int         doneCount = 0;
    int         errCount = 0;
    int         doneCycle = 0;
    int         errCycle = 0;
    int         firstDone = 0;

    uart_tx_sched #(
        .NREQ(NREQ),
        .TIMEOUT(TIMEOUT),
        .TO_W(16),
        .GAP_CYC(GAP_CYC),
        .GAP_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(reqData),
        .grant(grant),
        .tx_start(txStart),
        .tx_din(txDin),
        .tx_done_tick(txDone),
        .busy(busy),
        .frame_done(frameDone),
        .err_timeout(errTimeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in; shares reset, so a pending byte is dropped on reset.
    initial begin
        txDone = 1'b0;
        forever begin
            @(posedge clk);
            #4;
            if (reset) begin
                doneAt = -1;
                txDone = 1'b0;
            end else begin
                if (txStart === 1'b1) begin
                    if (startNo != skipIdx) begin
                        doneAt = cyc + ((startNo == longIdx) ? TIMEOUT : UART_LAT);
                    end
                    startNo++;
                end
                txDone = (cyc == doneAt) || (cyc == injectAt);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        req = r;
        reqData = d;
    endtask

    task automatic clearLogs();
        startBytes.delete();
        startCycles.delete();
        grantIdx.delete();
        grantCycles.delete();
        doneCount = 0;
        errCount = 0;
    endtask

    // Frame model: a granted frame owns the line from grant until its last
    // done (or the TIMEOUT-th cycle after a start), then the line rests GAP_CYC.
    task automatic modelCycle();
        logic [3:0] eGrant;
        logic       eStart;
        logic       eDone;
        logic       eErr;
        logic       eBusy;
        int         g;
        int         idx;
        if (txStart === 1'b1) begin
            startBytes.push_back(txDin);
            startCycles.push_back(cyc);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i] === 1'b1) begin
                grantIdx.push_back(i);
                grantCycles.push_back(cyc);
            end
        end
        if (frameDone === 1'b1) begin
            doneCount++;
            doneCycle = cyc;
        end
        if (errTimeout === 1'b1) begin
            errCount++;
            errCycle = cyc;
        end
        if (reset) begin
            mInFrame = 1'b0;
            mPtr = 0;
            mIdleFrom = cyc + 1;
            mDin = 8'h00;
            return;
        end
        eGrant = 4'b0000;
        eStart = 1'b0;
        eDone = 1'b0;
        eErr = 1'b0;
        eBusy = (mInFrame && cyc > mGrantCyc) || (cyc < mIdleFrom);
        if (!mInFrame && cyc >= mIdleFrom && req != 4'b0000) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (mPtr + k) % NREQ;
                if (g < 0 && req[idx]) g = idx;
            end
            eGrant[g] = 1'b1;
            mFrame[0] = 8'hA0 | 8'(g);
            mFrame[1] = reqData[8*g +: 8];
            mFrame[2] = mFrame[0] ^ mFrame[1];
            mPtr = (g + 1) % NREQ;
            mByteNo = 0;
            mLoadAt = cyc + 1;
            mGrantCyc = cyc;
            mInFrame = 1'b1;
        end else if (mInFrame) begin
            if (cyc == mLoadAt) begin
                eStart = 1'b1;
                mDin = mFrame[mByteNo];
            end else if (cyc > mLoadAt) begin
                if (txDone) begin
                    if (mByteNo < 2) begin
                        mByteNo++;
                        mLoadAt = cyc + 1;
                    end else begin
                        eDone = 1'b1;
                        mInFrame = 1'b0;
                        mIdleFrom = cyc + GAP_CYC + 1;
                    end
                end else if (cyc - mLoadAt == TIMEOUT) begin
                    eErr = 1'b1;
                    mInFrame = 1'b0;
                    mIdleFrom = cyc + GAP_CYC + 1;
                end
            end
        end
        checkOutput("grant", 32'(grant), 32'(eGrant));
        checkOutput("tx_start", 32'(txStart), 32'(eStart));
        checkOutput("tx_din", 32'(txDin), 32'(mDin));
        checkOutput("busy", 32'(busy), 32'(eBusy));
        checkOutput("frame_done", 32'(frameDone), 32'(eDone));
        checkOutput("err_timeout", 32'(errTimeout), 32'(eErr));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            modelCycle();
            @(posedge clk);
            #3;
        end
    endtask

    task automatic checkBytes(input string name, input logic [7:0] exp[$]);
        checkOutput({name, "_count"}, 32'(startBytes.size()), 32'(exp.size()));
        if (startBytes.size() == exp.size()) begin
            foreach (exp[i]) checkOutput(name, 32'(startBytes[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(4'b0000, 32'h0);
        step(2);
        reset = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tx_start", 32'(txStart), 32'd0);
        checkOutput("rst_tx_din", 32'(txDin), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);

        // single frame from requester 1
        clearLogs();
        applyStimulus(4'b0010, 32'h00005C00);
        step(1);
        applyStimulus(4'b0000, 32'h00005C00);
        step(44);
        checkBytes("t1_bytes", '{8'hA1, 8'h5C, 8'hFD});
        checkOutput("t1_grants", 32'(grantIdx.size()), 32'd1);
        if (grantIdx.size() == 1) checkOutput("t1_grant_idx", 32'(grantIdx[0]), 32'd1);
        checkOutput("t1_done_count", 32'(doneCount), 32'd1);
        if (startCycles.size() == 3) checkOutput("t1_done_lat", 32'(doneCycle - startCycles[2]), 32'd10);

        // round robin with every request held
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        clearLogs();
        applyStimulus(4'b1111, 32'h44332211);
        step(149);
        applyStimulus(4'b0000, 32'h44332211);
        step(40);
        checkOutput("t2_grants", 32'(grantIdx.size()), 32'd5);
        if (grantIdx.size() == 5) begin
            checkOutput("t2_g0", 32'(grantIdx[0]), 32'd0);
            checkOutput("t2_g1", 32'(grantIdx[1]), 32'd1);
            checkOutput("t2_g2", 32'(grantIdx[2]), 32'd2);
            checkOutput("t2_g3", 32'(grantIdx[3]), 32'd3);
            checkOutput("t2_g4", 32'(grantIdx[4]), 32'd0);
        end
        checkOutput("t2_starts", 32'(startBytes.size()), 32'd15);
        if (startBytes.size() == 15) begin
            checkOutput("t2_h0", 32'(startBytes[0]), 32'hA0);
            checkOutput("t2_h1", 32'(startBytes[3]), 32'hA1);
            checkOutput("t2_h2", 32'(startBytes[6]), 32'hA2);
            checkOutput("t2_h3", 32'(startBytes[9]), 32'hA3);
            checkOutput("t2_h4", 32'(startBytes[12]), 32'hA0);
            checkOutput("t2_chk0", 32'(startBytes[2]), 32'hB1);
        end

        // payload done suppressed -> timeout, then requester 2 served again
        clearLogs();
        skipIdx = startNo + 1;
        applyStimulus(4'b0100, 32'h003C0000);
        step(67);
        applyStimulus(4'b0000, 32'h003C0000);
        step(40);
        checkOutput("t3_err_count", 32'(errCount), 32'd1);
        checkOutput("t3_done_count", 32'(doneCount), 32'd1);
        checkBytes("t3_bytes", '{8'hA2, 8'h3C, 8'hA2, 8'h3C, 8'h9E});
        if (startCycles.size() == 5) checkOutput("t3_err_lat", 32'(errCycle - startCycles[1]), 32'd50);
        if (grantCycles.size() == 2) checkOutput("t3_regrant", 32'(grantCycles[1] - errCycle), 32'd4);

        // done tick lands on the final timeout cycle
        clearLogs();
        longIdx = startNo + 1;
        applyStimulus(4'b1000, 32'h07000000);
        step(1);
        applyStimulus(4'b0000, 32'h07000000);
        step(85);
        checkOutput("t4_err_count", 32'(errCount), 32'd0);
        checkOutput("t4_done_count", 32'(doneCount), 32'd1);
        checkBytes("t4_bytes", '{8'hA3, 8'h07, 8'hA4});
        if (startCycles.size() == 3) checkOutput("t4_gap", 32'(startCycles[2] - startCycles[1]), 32'd51);

        // reset while waiting on the payload byte
        clearLogs();
        applyStimulus(4'b0001, 32'h000000C3);
        step(1);
        applyStimulus(4'b0000, 32'h000000C3);
        step(19);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_tx_start", 32'(txStart), 32'd0);
        checkOutput("t5_tx_din", 32'(txDin), 32'd0);
        checkOutput("t5_grant", 32'(grant), 32'd0);
        step(5);
        applyStimulus(4'b1000, 32'h5A000000);
        step(1);
        applyStimulus(4'b0000, 32'h5A000000);
        step(40);
        checkBytes("t5_bytes", '{8'hA0, 8'hC3, 8'hA3, 8'h5A, 8'hF9});
        checkOutput("t5_done_count", 32'(doneCount), 32'd1);
        if (grantIdx.size() == 2) checkOutput("t5_regrant_idx", 32'(grantIdx[1]), 32'd3);

        // request raised and stray done injected during the gap
        clearLogs();
        applyStimulus(4'b0010, 32'h00001000);
        step(1);
        applyStimulus(4'b0000, 32'h00001000);
        step(33);
        applyStimulus(4'b0100, 32'h00770000);
        injectAt = cyc + 1;
        step(4);
        firstDone = doneCycle;
        applyStimulus(4'b0000, 32'h00770000);
        step(40);
        checkOutput("t6_grants", 32'(grantIdx.size()), 32'd2);
        if (grantIdx.size() == 2) begin
            checkOutput("t6_idx", 32'(grantIdx[1]), 32'd2);
            checkOutput("t6_lat", 32'(grantCycles[1] - firstDone), 32'd4);
        end
        checkOutput("t6_err_count", 32'(errCount), 32'd0);
        checkOutput("t6_done_count", 32'(doneCount), 32'd2);
        if (startBytes.size() == 6) checkOutput("t6_hdr", 32'(startBytes[3]), 32'hA2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
